obstacle_field_controller: RTL and testbench

//  Parametrised successor to the single-block game controller. Runs one player block
//  and N_OBS falling obstacles, and adds collision detection, scoring, lives,

---
 rtl/obstacle_field_controller.sv | 205 ++++++++++++++++++++
 tb/tb_obstacle_field_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_field_controller.sv
// Game controller for one player square and N_OBS falling obstacles.
// It handles collision, scoring, lives and an IDLE/PLAY/HIT/OVER flow, and rgb is decoded per pixel.
module obstacle_field_controller #(
  parameter int N_OBS        = 4,
  parameter int BLK_HALF     = 15,
  parameter int OBS_HALF_W   = 40,
  parameter int OBS_HALF_H   = 10,
  parameter int STEP         = 2,
  parameter int OBS_STEP     = 2,
  parameter int MAX_OBS_STEP = 6,
  parameter int LIVES        = 3,
  parameter int WRAP_EN      = 0,
  parameter int H_MIN        = 144,
  parameter int H_MAX        = 783,
  parameter int V_MIN        = 35,
  parameter int V_MAX        = 515
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bright,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        start,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [11:0] rgb,
  output logic [11:0] background,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_t;

  localparam logic signed [10:0] PX_MIN  = 11'(H_MIN + BLK_HALF);
  localparam logic signed [10:0] PX_MAX  = 11'(H_MAX - BLK_HALF);
  localparam logic signed [10:0] PY_MIN  = 11'(V_MIN + BLK_HALF);
  localparam logic signed [10:0] PY_MAX  = 11'(V_MAX - BLK_HALF);
  localparam logic signed [10:0] PX_INIT = 11'd463;
  localparam logic signed [10:0] PY_INIT = 11'd450;
  localparam logic signed [10:0] YMIN_S  = 11'(V_MIN);
  localparam logic signed [10:0] YMAX_S  = 11'(V_MAX);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] BLK_S   = 11'(BLK_HALF);
  localparam logic signed [10:0] OHW_S   = 11'(OBS_HALF_W);
  localparam logic signed [10:0] OHH_S   = 11'(OBS_HALF_H);
  localparam logic signed [10:0] COL_W   = 11'(BLK_HALF + OBS_HALF_W);
  localparam logic signed [10:0] COL_H   = 11'(BLK_HALF + OBS_HALF_H);
  localparam logic signed [10:0] SPD_CAP = 11'(MAX_OBS_STEP);
  localparam logic [16:0]        SPD_MAX = 17'(MAX_OBS_STEP);

  function automatic logic signed [10:0] abs11(input logic signed [10:0] a);
    return (a < 0) ? -a : a;
  endfunction

  state_t                   state_reg, state_next;
  logic signed [10:0]       px_reg, px_next, py_reg, py_next;
  logic [N_OBS-1:0][10:0]   oy_reg, oy_next, oy_init;
  logic [15:0]              score_reg, score_next;
  logic [2:0]               lives_reg, lives_next;
  logic [11:0]              bg_reg, bg_next;
  logic [4:0]               hit_cnt_reg, hit_cnt_next;
  logic [N_OBS-1:0]         wrap_vec, hit_vec, pix_vec;
  logic [16:0]              spd_raw, score_sum;
  logic signed [10:0]       spd, h_s, v_s, px_inc, px_dec, py_inc, py_dec;
  logic                     collide, obs_move, pos_reload, player_pix;

  assign h_s     = $signed({1'b0, hCount});
  assign v_s     = $signed({1'b0, vCount});
  assign px_inc  = px_reg + STEP_S;
  assign px_dec  = px_reg - STEP_S;
  assign py_inc  = py_reg + STEP_S;
  assign py_dec  = py_reg - STEP_S;
  // Fall speed rises by one every 8 points, capped.
  assign spd_raw = 17'(OBS_STEP) + {4'd0, score_reg[15:3]};
  assign spd     = (spd_raw > SPD_MAX) ? SPD_CAP : $signed(spd_raw[10:0]);
  assign collide = |hit_vec;

  genvar gi;
  for (gi = 0; gi < N_OBS; gi++) begin : g_obs
    localparam logic signed [10:0] OX  = 11'(H_MIN + ((2 * gi + 1) * (H_MAX - H_MIN + 1)) / (2 * N_OBS));
    localparam logic signed [10:0] OY0 = 11'(V_MIN + gi * ((V_MAX - V_MIN) / N_OBS));
    logic signed [10:0] oy, oy_sum;
    assign oy           = $signed(oy_reg[gi]);
    assign oy_sum       = oy + spd;
    assign oy_init[gi]  = OY0;
    assign wrap_vec[gi] = oy_sum > YMAX_S;
    assign hit_vec[gi]  = (abs11(px_reg - OX) <= COL_W) && (abs11(py_reg - oy) <= COL_H);
    assign pix_vec[gi]  = (abs11(h_s - OX) <= OHW_S) && (abs11(v_s - oy) <= OHH_S);
    assign oy_next[gi]  = pos_reload ? OY0 : (obs_move ? (wrap_vec[gi] ? YMIN_S : oy_sum) : oy);
  end

  always_comb begin
    score_sum = {1'b0, score_reg};
    for (int i = 0; i < N_OBS; i++) score_sum = score_sum + 17'(wrap_vec[i]);
  end

  always_ff @(posedge clk) begin : state_register
    if (rst) begin
      state_reg   <= IDLE;
      px_reg      <= PX_INIT;
      py_reg      <= PY_INIT;
      oy_reg      <= oy_init;
      score_reg   <= 16'd0;
      lives_reg   <= 3'(LIVES);
      bg_reg      <= 12'hFFF;
      hit_cnt_reg <= 5'd0;
    end else begin
      state_reg   <= state_next;
      px_reg      <= px_next;
      py_reg      <= py_next;
      oy_reg      <= oy_next;
      score_reg   <= score_next;
      lives_reg   <= lives_next;
      bg_reg      <= bg_next;
      hit_cnt_reg <= hit_cnt_next;
    end
  end

  always_comb begin : next_state_logic
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = PLAY;
      PLAY:    if (collide) state_next = HIT;
      HIT:     if (hit_cnt_reg == 5'd0) state_next = (lives_reg == 3'd0) ? OVER : PLAY;
      OVER:    if (start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin : datapath_next
    px_next      = px_reg;
    py_next      = py_reg;
    score_next   = score_reg;
    lives_next   = lives_reg;
    bg_next      = bg_reg;
    hit_cnt_next = hit_cnt_reg;
    obs_move     = 1'b0;
    pos_reload   = 1'b0;
    unique case (state_reg)
      PLAY: begin
        if (collide) begin
          lives_next   = lives_reg - 3'd1;
          bg_next      = 12'hF80;
          hit_cnt_next = 5'd31;
        end else begin
          obs_move   = 1'b1;
          score_next = (score_sum > 17'h0FFFF) ? 16'hFFFF : score_sum[15:0];
          if (right) begin
            px_next = (px_inc > PX_MAX) ? ((WRAP_EN != 0) ? PX_MIN : PX_MAX) : px_inc;
            bg_next = 12'hFF0;
          end else if (left) begin
            px_next = (px_dec < PX_MIN) ? ((WRAP_EN != 0) ? PX_MAX : PX_MIN) : px_dec;
            bg_next = 12'h0FF;
          end else if (up) begin
            py_next = (py_dec < PY_MIN) ? ((WRAP_EN != 0) ? PY_MAX : PY_MIN) : py_dec;
            bg_next = 12'h00F;
          end else if (down) begin
            py_next = (py_inc > PY_MAX) ? ((WRAP_EN != 0) ? PY_MIN : PY_MAX) : py_inc;
            bg_next = 12'h0F0;
          end
        end
      end
      HIT: begin
        if (hit_cnt_reg != 5'd0) begin
          hit_cnt_next = hit_cnt_reg - 5'd1;
        end else if (lives_reg != 3'd0) begin
          pos_reload = 1'b1;
          px_next    = PX_INIT;
          py_next    = PY_INIT;
        end else begin
          bg_next = 12'h444;
        end
      end
      OVER: begin
        // Restart from OVER lands in the same state a reset produces.
        if (start) begin
          pos_reload   = 1'b1;
          px_next      = PX_INIT;
          py_next      = PY_INIT;
          score_next   = 16'd0;
          lives_next   = 3'(LIVES);
          bg_next      = 12'hFFF;
          hit_cnt_next = 5'd0;
        end
      end
      default: ;
    endcase
  end

  assign player_pix = (abs11(h_s - px_reg) <= BLK_S) && (abs11(v_s - py_reg) <= BLK_S);

  always_comb begin : pixel_output
    if (!bright)         rgb = 12'h000;
    else if (player_pix) rgb = 12'hF00;
    else if (|pix_vec)   rgb = 12'hF0F;
    else                 rgb = bg_reg;
  end

  assign background = bg_reg;
  assign score      = score_reg;
  assign lives      = lives_reg;
  assign state      = state_reg;
endmodule

// File: tb/tb_obstacle_field_controller.sv
// Bench for obstacle_field_controller: three instances (default, WRAP_EN=1, LIVES=1) share the stimulus.
// A game-level model is compared against every instance each cycle, and literal checks pin the model.
`timescale 1ns/1ps
module tb_obstacle_field_controller;
  localparam int NI = 3;
  localparam int OX      [4]  = '{224, 384, 544, 704};
  localparam int OY0     [4]  = '{35, 155, 275, 395};
  localparam int WRAP_P  [NI] = '{0, 1, 0};
  localparam int LIVES_P [NI] = '{3, 3, 1};

  logic clk = 1'b0;
  logic rst, up, down, left, right, start;
  logic        bright_i [NI] = '{default: 1'b1};
  logic [9:0]  hc [NI] = '{default: 10'd0};
  logic [9:0]  vc [NI] = '{default: 10'd0};
  logic [11:0] rgb_o [NI];
  logic [11:0] bg_o [NI];
  logic [15:0] score_o [NI];
  logic [2:0]  lives_o [NI];
  logic [1:0]  state_o [NI];

  int n_pass = 0, n_total = 0, cyc = 0;
  bit chk_en = 1'b0;

  int m_state [NI], m_score [NI], m_lives [NI], m_bg [NI];
  int m_px [NI], m_py [NI], m_age [NI];
  int m_oy [NI][4];

  always #10 clk = ~clk;

  obstacle_field_controller #(.WRAP_EN(0), .LIVES(3)) dut_a (
    .clk(clk), .rst(rst), .bright(bright_i[0]), .up(up), .down(down), .left(left), .right(right),
    .start(start), .hCount(hc[0]), .vCount(vc[0]), .rgb(rgb_o[0]), .background(bg_o[0]),
    .score(score_o[0]), .lives(lives_o[0]), .state(state_o[0]));
  obstacle_field_controller #(.WRAP_EN(1), .LIVES(3)) dut_w (
    .clk(clk), .rst(rst), .bright(bright_i[1]), .up(up), .down(down), .left(left), .right(right),
    .start(start), .hCount(hc[1]), .vCount(vc[1]), .rgb(rgb_o[1]), .background(bg_o[1]),
    .score(score_o[1]), .lives(lives_o[1]), .state(state_o[1]));
  obstacle_field_controller #(.WRAP_EN(0), .LIVES(1)) dut_l (
    .clk(clk), .rst(rst), .bright(bright_i[2]), .up(up), .down(down), .left(left), .right(right),
    .start(start), .hCount(hc[2]), .vCount(vc[2]), .rgb(rgb_o[2]), .background(bg_o[2]),
    .score(score_o[2]), .lives(lives_o[2]), .state(state_o[2]));

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset(input int k);
    m_state[k] = 0; m_score[k] = 0; m_lives[k] = LIVES_P[k]; m_bg[k] = 'hFFF;
    m_px[k] = 463; m_py[k] = 450; m_age[k] = 0;
    for (int i = 0; i < 4; i++) m_oy[k][i] = OY0[i];
  endtask

  // Game rules at the level of "what happens this tick", in plain integers.
  task automatic model_tick(input int k);
    bit hit;
    int spd, np;
    if (rst) begin model_reset(k); return; end
    case (m_state[k])
      0: if (start) m_state[k] = 1;
      1: begin
        hit = 0;
        for (int i = 0; i < 4; i++)
          if (iabs(m_px[k] - OX[i]) <= 55 && iabs(m_py[k] - m_oy[k][i]) <= 25) hit = 1;
        if (hit) begin
          m_lives[k]--; m_bg[k] = 'hF80; m_state[k] = 2; m_age[k] = 0;
        end else begin
          spd = 2 + m_score[k] / 8;
          if (spd > 6) spd = 6;
          for (int i = 0; i < 4; i++) begin
            if (m_oy[k][i] + spd > 515) begin
              m_oy[k][i] = 35;
              if (m_score[k] < 65535) m_score[k]++;
            end else m_oy[k][i] += spd;
          end
          if (right) begin
            np = m_px[k] + 2; if (np > 768) np = WRAP_P[k] ? 159 : 768;
            m_px[k] = np; m_bg[k] = 'hFF0;
          end else if (left) begin
            np = m_px[k] - 2; if (np < 159) np = WRAP_P[k] ? 768 : 159;
            m_px[k] = np; m_bg[k] = 'h0FF;
          end else if (up) begin
            np = m_py[k] - 2; if (np < 50) np = WRAP_P[k] ? 500 : 50;
            m_py[k] = np; m_bg[k] = 'h00F;
          end else if (down) begin
            np = m_py[k] + 2; if (np > 500) np = WRAP_P[k] ? 50 : 500;
            m_py[k] = np; m_bg[k] = 'h0F0;
          end
        end
      end
      2: begin
        m_age[k]++;
        if (m_age[k] == 32) begin
          if (m_lives[k] == 0) begin
            m_state[k] = 3; m_bg[k] = 'h444;
          end else begin
            m_state[k] = 1; m_px[k] = 463; m_py[k] = 450;
            for (int i = 0; i < 4; i++) m_oy[k][i] = OY0[i];
          end
        end
      end
      default: if (start) model_reset(k);
    endcase
  endtask

  function automatic int model_rgb(input int k, input int h, input int v, input bit b);
    if (!b) return 0;
    if (iabs(h - m_px[k]) <= 15 && iabs(v - m_py[k]) <= 15) return 'hF00;
    for (int i = 0; i < 4; i++)
      if (iabs(h - OX[i]) <= 40 && iabs(v - m_oy[k][i]) <= 10) return 'hF0F;
    return m_bg[k];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) model_tick(k);
  end

  // Per-cycle compare: registered outputs, then rgb at a set of probe pixels.
  always @(negedge clk) begin
    int j, ph, pv;
    if (chk_en) begin
      cyc++;
      j = cyc % 4;
      for (int k = 0; k < NI; k++) begin
        check($sformatf("state[%0d]", k), state_o[k], m_state[k]);
        check($sformatf("score[%0d]", k), score_o[k], m_score[k]);
        check($sformatf("lives[%0d]", k), lives_o[k], m_lives[k]);
        check($sformatf("background[%0d]", k), bg_o[k], m_bg[k]);
      end
      for (int p = 0; p < 7; p++) begin
        for (int k = 0; k < NI; k++) begin
          case (p)
            0: begin ph = m_px[k];      pv = m_py[k];           end
            1: begin ph = m_px[k] + 16; pv = m_py[k];           end
            2: begin ph = m_px[k] - 15; pv = m_py[k] + 15;      end
            3: begin ph = OX[j];        pv = m_oy[k][j];        end
            4: begin ph = OX[j] + 40;   pv = m_oy[k][j] - 10;   end
            5: begin ph = OX[j] - 41;   pv = m_oy[k][j] + 11;   end
            default: begin ph = m_px[k]; pv = m_py[k];          end
          endcase
          hc[k] = 10'(ph); vc[k] = 10'(pv); bright_i[k] = (p != 6);
        end
        #1;
        for (int k = 0; k < NI; k++)
          check($sformatf("rgb[%0d] probe%0d @(%0d,%0d)", k, p, hc[k], vc[k]), rgb_o[k],
                model_rgb(k, hc[k], vc[k], bright_i[k]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic restart_play();
    rst = 1; step(1); rst = 0;
    start = 1; step(1); start = 0;
  endtask

  initial begin
    int waited;
    int y_prev [4];
    rst = 1; up = 0; down = 0; left = 0; right = 0; start = 0;
    @(posedge clk); #1; chk_en = 1'b1;
    step(1);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_state[%0d]", k), state_o[k], 0);
      check($sformatf("reset_score[%0d]", k), score_o[k], 0);
      check($sformatf("reset_lives[%0d]", k), lives_o[k], LIVES_P[k]);
      check($sformatf("reset_bg[%0d]", k), bg_o[k], 'hFFF);
    end

    // Buttons in IDLE do nothing; start enters PLAY without moving anything.
    rst = 0; right = 1; step(3); right = 0;
    check("idle_bg", bg_o[0], 'hFFF);
    check("idle_state", state_o[0], 0);
    check("idle_px", m_px[0], 463);
    start = 1; step(1); start = 0;
    for (int k = 0; k < NI; k++) check($sformatf("start_state[%0d]", k), state_o[k], 1);
    check("start_y0", m_oy[0][0], 35);
    step(1);
    check("tick1_y0", m_oy[0][0], 37);
    check("tick1_y3", m_oy[0][3], 397);
    check("tick1_px", m_px[0], 463);
    check("tick1_py", m_py[0], 450);
    check("tick1_score", score_o[0], 0);
    step(59);
    check("tick60_score", score_o[0], 0);
    check("tick60_y3", m_oy[0][3], 515);
    step(1);
    for (int k = 0; k < NI; k++) check($sformatf("tick61_score[%0d]", k), score_o[k], 1);
    check("tick61_y3", m_oy[0][3], 35);
    check("tick61_state", state_o[0], 1);
    $display("scenario fall: score=%0d state=%0d", score_o[0], state_o[0]);

    // Right held (all four buttons for the first 10 ticks) to the right edge.
    restart_play();
    right = 1; left = 1; up = 1; down = 1; step(10);
    left = 0; up = 0; down = 0;
    check("prio_px", m_px[0], 483);
    step(143);
    check("clamp_px", m_px[0], 768);
    check("wrap_px", m_px[1], 159);
    check("clamp_px_l", m_px[2], 768);
    check("right_py", m_py[0], 450);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("right_bg[%0d]", k), bg_o[k], 'hFF0);
      check($sformatf("right_state[%0d]", k), state_o[k], 1);
    end
    step(17);
    check("clamp_hold_px", m_px[0], 768);
    check("wrap_cont_px", m_px[1], 193);
    check("wrap_state", state_o[1], 1);
    right = 0;
    $display("scenario edge: bg=%0h state=%0d/%0d", bg_o[0], state_o[0], state_o[1]);

    // Left into lane 1, wait for obstacle 1 to reach the player.
    restart_play();
    left = 1; step(40); left = 0;
    for (int k = 0; k < NI; k++) check($sformatf("lane1_px[%0d]", k), m_px[k], 383);
    step(95);
    check("prehit_state", state_o[0], 1);
    check("prehit_y1", m_oy[0][1], 425);
    step(1);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("hit_state[%0d]", k), state_o[k], 2);
      check($sformatf("hit_lives[%0d]", k), lives_o[k], LIVES_P[k] - 1);
      check($sformatf("hit_bg[%0d]", k), bg_o[k], 'hF80);
      check($sformatf("hit_score[%0d]", k), score_o[k], 2);
    end
    start = 1; step(3); start = 0; step(28);
    for (int k = 0; k < NI; k++) check($sformatf("hit31_state[%0d]", k), state_o[k], 2);
    step(1);
    check("resume_state", state_o[0], 1);
    check("resume_state_w", state_o[1], 1);
    check("over_state", state_o[2], 3);
    check("over_bg", bg_o[2], 'h444);
    check("resume_bg", bg_o[0], 'hF80);
    check("resume_lives", lives_o[0], 2);
    check("resume_score", score_o[0], 2);
    check("resume_px", m_px[0], 463);
    check("resume_y1", m_oy[0][1], 155);
    start = 1; step(1); start = 0;
    check("play_ignores_start", state_o[0], 1);
    check("over_restart_state", state_o[2], 0);
    check("over_restart_score", score_o[2], 0);
    check("over_restart_lives", lives_o[2], 1);
    check("over_restart_bg", bg_o[2], 'hFFF);
    $display("scenario collision: lives=%0d/%0d state=%0d/%0d", lives_o[0], lives_o[2], state_o[0], state_o[2]);

    // Reset in the middle of HIT.
    restart_play();
    left = 1; step(40); left = 0; step(96);
    check("hit2_state", state_o[0], 2);
    step(5);
    rst = 1; step(1); rst = 0;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("midhit_rst_state[%0d]", k), state_o[k], 0);
      check($sformatf("midhit_rst_lives[%0d]", k), lives_o[k], LIVES_P[k]);
      check($sformatf("midhit_rst_score[%0d]", k), score_o[k], 0);
      check($sformatf("midhit_rst_bg[%0d]", k), bg_o[k], 'hFFF);
    end
    $display("scenario reset-in-hit: state=%0d", state_o[0]);

    // Speed levels: score 8 raises spd to 3; by score 40 spd is capped at 6.
    start = 1; step(1); start = 0;
    step(481);
    check("score_481", score_o[0], 7);
    step(1);
    check("score_482", score_o[0], 8);
    check("y3_482", m_oy[0][3], 395);
    step(1);
    check("y3_spd3", m_oy[0][3], 398);
    waited = 0;
    while (score_o[0] < 16'd40 && waited < 4000) begin step(1); waited++; end
    check("score40_reached", score_o[0] >= 16'd40, 1);
    for (int i = 0; i < 4; i++) y_prev[i] = m_oy[0][i];
    step(1);
    for (int i = 0; i < 4; i++)
      if (m_oy[0][i] != 35) check($sformatf("spd_cap_y%0d", i), m_oy[0][i] - y_prev[i], 6);
    $display("scenario speed: score=%0d after %0d extra ticks", score_o[0], waited);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
